// File: rtl/gf180mcu_fd_sc_mcu7t5v0__inv_filt.sv
// Per-channel inverter/buffer with input synchroniser and a consecutive-sample debounce filter.
// Each output is the filtered state XOR polarity; CHG pulses for one cycle when a filtered state flips.
module gf180mcu_fd_sc_mcu7t5v0__inv_filt #(
  parameter int WIDTH       = 4,
  parameter int FILT_CYC    = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             EN,
  input  logic [WIDTH-1:0] I,
  input  logic [WIDTH-1:0] POL,
  output logic [WIDTH-1:0] ZN,
  output logic [WIDTH-1:0] CHG
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("WIDTH must be in 1..32");
  end
  if (FILT_CYC < 1 || FILT_CYC > 15) begin : g_bad_filt
    $error("FILT_CYC must be in 1..15");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
    $error("SYNC_STAGES must be in 2..3");
  end

  localparam int CW = $clog2(FILT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYC - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] filt_q;
  logic [WIDTH-1:0] filt_d;
  logic [WIDTH-1:0] chg_q;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];

  assign s = sync_q[SYNC_STAGES-1];

  // Counter only advances while the synchronised sample disagrees with the
  // filtered state; any agreement (or bypass) throws away a partial count.
  always_comb begin
    filt_d = filt_q;
    for (int k = 0; k < WIDTH; k++) begin
      cnt_d[k] = '0;
      if (!EN) begin
        filt_d[k] = s[k];
      end else if (s[k] != filt_q[k]) begin
        if (cnt_q[k] == CNT_LAST) begin
          filt_d[k] = s[k];
        end else begin
          cnt_d[k] = cnt_q[k] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      filt_q <= '0;
      chg_q  <= '0;
      for (int k = 0; k < WIDTH; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= I;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      filt_q <= filt_d;
      chg_q  <= filt_d ^ filt_q;
      for (int k = 0; k < WIDTH; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  // Polarity is applied after the filter so it never produces a CHG pulse.
  assign ZN  = filt_q ^ POL;
  assign CHG = chg_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__inv_filt.sv
// Bench for the filtered inverter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a delay-line/streak model.
module tb_gf180mcu_fd_sc_mcu7t5v0__inv_filt;

  localparam int WIDTH       = 4;
  localparam int FILT_CYC    = 3;
  localparam int SYNC_STAGES = 2;

  logic             CLK = 1'b0;
  logic             RN  = 1'b0;
  logic             EN  = 1'b1;
  logic [WIDTH-1:0] I   = '0;
  logic [WIDTH-1:0] POL = 4'b1010;
  logic [WIDTH-1:0] ZN;
  logic [WIDTH-1:0] CHG;

  int passed = 0;
  int total  = 0;
  bit cmp_on = 1'b1;

  gf180mcu_fd_sc_mcu7t5v0__inv_filt #(
    .WIDTH(WIDTH), .FILT_CYC(FILT_CYC), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .CLK(CLK), .RN(RN), .EN(EN), .I(I), .POL(POL), .ZN(ZN), .CHG(CHG)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the synchroniser is a plain delay line of input samples;
  // a channel's filtered value follows the sample once it has disagreed for
  // FILT_CYC edges in a row with the filter enabled, or at once when bypassed.
  logic [WIDTH-1:0] hist_q[$];
  logic [WIDTH-1:0] f_m   = '0;
  logic [WIDTH-1:0] chg_m = '0;
  int               streak [WIDTH];

  task automatic model_reset();
    hist_q.delete();
    repeat (SYNC_STAGES) hist_q.push_back('0);
    f_m   = '0;
    chg_m = '0;
    for (int k = 0; k < WIDTH; k++) streak[k] = 0;
  endtask

  always @(posedge CLK or negedge RN) begin : model
    logic [WIDTH-1:0] smp;
    logic [WIDTH-1:0] nf;
    if (!RN) begin
      model_reset();
    end else begin
      smp = hist_q.pop_front();
      hist_q.push_back(I);
      nf = f_m;
      for (int k = 0; k < WIDTH; k++) begin
        if (!EN) begin
          nf[k] = smp[k];
          streak[k] = 0;
        end else if (smp[k] != f_m[k]) begin
          streak[k]++;
          if (streak[k] >= FILT_CYC) begin
            nf[k] = smp[k];
            streak[k] = 0;
          end
        end else begin
          streak[k] = 0;
        end
      end
      chg_m = nf ^ f_m;
      f_m   = nf;
    end
  end

  // scoreboard compare, every cycle away from the active edge
  always @(negedge CLK) begin
    if (cmp_on) begin
      check("cyc_zn", 32'(ZN), 32'(f_m ^ POL));
      check("cyc_chg", 32'(CHG), 32'(chg_m));
    end
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    // reset state and idle hold
    #3;
    check("rst_zn", 32'(ZN), 32'h0A);
    check("rst_chg", 32'(CHG), 32'h0);
    step();
    RN = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      step();
      check("idle_zn", 32'(ZN), 32'h0A);
      check("idle_chg", 32'(CHG), 32'h0);
    end

    // held change on channel 0, filter enabled
    POL  = 4'hF;
    I[0] = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step();
      check("lat_zn0", 32'(ZN[0]), (e >= 5) ? 0 : 1);
      check("lat_chg0", 32'(CHG[0]), (e == 5) ? 1 : 0);
    end

    // two-cycle glitch on channel 1 is rejected
    I[1] = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      if (e == 2) I[1] = 1'b0;
      check("glitch_zn1", 32'(ZN[1]), 1);
      check("glitch_chg1", 32'(CHG[1]), 0);
    end

    // bypass on channel 2
    EN   = 1'b0;
    I[2] = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      step();
      check("byp_zn2", 32'(ZN[2]), (e >= 3) ? 0 : 1);
      check("byp_chg2", 32'(CHG[2]), (e == 3) ? 1 : 0);
    end
    EN = 1'b1;

    // reset mid-count on channel 3
    I[3] = 1'b1;
    for (int e = 1; e <= 3; e++) step();
    RN = 1'b0;
    #1;
    check("midrst_zn", 32'(ZN), 32'hF);
    check("midrst_chg", 32'(CHG), 32'h0);
    #4;
    RN = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step();
      check("post_rst_zn3", 32'(ZN[3]), (e == 5) ? 0 : 1);
      check("post_rst_chg3", 32'(CHG[3]), (e == 5) ? 1 : 0);
    end

    // polarity flip in steady state
    for (int e = 1; e <= 10; e++) step();
    check("steady_zn", 32'(ZN), 32'b0010);
    POL = 4'h0;
    #1;
    check("pol_zn", 32'(ZN), 32'b1101);
    check("pol_chg", 32'(CHG), 32'h0);

    // randomized traffic
    for (int blk = 0; blk < 30; blk++) begin
      int rate;
      rate = $urandom_range(2, 12);
      for (int c = 0; c < 100; c++) begin
        step();
        for (int k = 0; k < WIDTH; k++)
          if ($urandom_range(0, rate - 1) == 0) I[k] = ~I[k];
        if ($urandom_range(0, 39) == 0) EN = ~EN;
        if ($urandom_range(0, 49) == 0) POL = WIDTH'($urandom);
        if ($urandom_range(0, 299) == 0) begin
          RN = 1'b0;
          #5;
          RN = 1'b1;
        end
      end
    end

    step();
    cmp_on = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
